// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: bus records,
// opcode and exception constants, and the request FSM state type.
package mem_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] ALUopR = 7'b0110011;
  localparam logic [6:0] ALUopI = 7'b0010011;
  localparam logic [6:0] NOP    = 7'b0000000;

  localparam logic [2:0] EXC_NONE           = 3'd0;
  localparam logic [2:0] EXC_LOAD_MISALIGN  = 3'd1;
  localparam logic [2:0] EXC_STORE_MISALIGN = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  typedef struct packed {
    logic            valid;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [31:0]     inst;
  } ex_mem_bus_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [XLEN-1:0] wb_value;
  } mem_wb_bus_t;

  localparam mem_wb_bus_t WB_BUBBLE = '{opcode: NOP, rd: 5'd0, wb_value: '0};

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port: valid/ready request channel plus a
// single-beat response (read data or store acknowledge).
interface mem_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            dreq_valid;
  logic            dreq_ready;
  logic            dreq_we;
  logic [XLEN-1:0] dreq_addr;
  logic [XLEN-1:0] dreq_wdata;
  logic            dresp_valid;
  logic [XLEN-1:0] dresp_rdata;

  modport master (
    output dreq_valid, dreq_we, dreq_addr, dreq_wdata,
    input  dreq_ready, dresp_valid, dresp_rdata
  );

  modport slave (
    input  dreq_valid, dreq_we, dreq_addr, dreq_wdata,
    output dreq_ready, dresp_valid, dresp_rdata
  );
endinterface

// File: rtl/mem_stage_req_fsm.sv
// Request sequencer for the memory stage: IDLE/REQ/WAIT, flush drop flag,
// registered dreq_* outputs and upstream stall generation.
module mem_req_fsm
  import mem_stage_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  mem_stage_if.master     dmem,
  output logic            busy,
  output logic            stall_out,
  output logic            resp_fire,
  output logic [6:0]      op_q,
  output logic [4:0]      rd_q
);

  mem_state_t state;
  logic       drop;

  assign busy      = (state != IDLE);
  // A flush arriving with the response kills it just like an earlier one.
  assign resp_fire = (state == WAIT) && dmem.dresp_valid && !drop && !flush;

  always_comb begin
    stall_out = 1'b0;
    case (state)
      IDLE:    stall_out = start;
      REQ:     stall_out = 1'b1;
      WAIT:    stall_out = !dmem.dresp_valid;
      default: stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      drop            <= 1'b0;
      dmem.dreq_valid <= 1'b0;
      dmem.dreq_we    <= 1'b0;
      dmem.dreq_addr  <= '0;
      dmem.dreq_wdata <= '0;
      op_q            <= NOP;
      rd_q            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dmem.dreq_valid <= 1'b1;
            dmem.dreq_we    <= (opcode == SW);
            dmem.dreq_addr  <= addr;
            dmem.dreq_wdata <= wdata;
            op_q            <= opcode;
            rd_q            <= rd;
            drop            <= 1'b0;
            state           <= REQ;
          end
        end
        REQ: begin
          // Once the handshake completes the response must still be consumed.
          if (dmem.dreq_ready) begin
            dmem.dreq_valid <= 1'b0;
            drop            <= flush;
            state           <= WAIT;
          end else if (flush) begin
            dmem.dreq_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        WAIT: begin
          if (dmem.dresp_valid) begin
            drop  <= 1'b0;
            state <= IDLE;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and writeback: issues LW/SW on the
// data-memory port, builds the writeback record and flags misaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = mem_stage_pkg::XLEN
) (
  input  logic         clock,
  input  logic         reset,
  input  ex_mem_bus_t  ex_mem_bus_in,
  input  logic         flush,
  output logic         stall_out,
  mem_stage_if.master  dmem,
  output mem_wb_bus_t  mem_wb_bus_out,
  output logic [2:0]   excpt_out,
  output logic [31:0]  excpt_inst_out
);

  logic [XLEN-1:0] alu_result;
  logic            ex_live;
  logic            is_mem;
  logic            misaligned;
  logic            start;
  logic            busy;
  logic            resp_fire;
  logic [6:0]      op_q;
  logic [4:0]      rd_q;

  assign alu_result = ex_mem_bus_in.alu_result;
  assign ex_live    = ex_mem_bus_in.valid && !flush;
  assign is_mem     = is_mem_op(ex_mem_bus_in.opcode);
  assign misaligned = (alu_result[1:0] != 2'b00);
  assign start      = ex_live && is_mem && !misaligned;

  mem_req_fsm u_req_fsm (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .opcode    (ex_mem_bus_in.opcode),
    .rd        (ex_mem_bus_in.rd),
    .addr      (alu_result),
    .wdata     (ex_mem_bus_in.store_data),
    .dmem      (dmem),
    .busy      (busy),
    .stall_out (stall_out),
    .resp_fire (resp_fire),
    .op_q      (op_q),
    .rd_q      (rd_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_wb_bus_out <= WB_BUBBLE;
      excpt_out      <= EXC_NONE;
      excpt_inst_out <= '0;
    end else begin
      mem_wb_bus_out <= WB_BUBBLE;
      excpt_out      <= EXC_NONE;
      excpt_inst_out <= '0;
      if (resp_fire) begin
        mem_wb_bus_out <= '{opcode:   op_q,
                            rd:       rd_q,
                            wb_value: (op_q == LW) ? dmem.dresp_rdata : '0};
      end else if (!busy && ex_live) begin
        if (!is_mem) begin
          mem_wb_bus_out <= '{opcode:   ex_mem_bus_in.opcode,
                              rd:       ex_mem_bus_in.rd,
                              wb_value: alu_result};
        end else if (misaligned) begin
          excpt_out      <= (ex_mem_bus_in.opcode == LW) ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
          excpt_inst_out <= ex_mem_bus_in.inst;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for multi-cycle
// cases, then a randomized run against a transaction-level memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  ex_mem_bus_t ex;
  logic        flush;
  logic        stall_out;
  mem_wb_bus_t wb;
  logic [2:0]  exc;
  logic [31:0] exc_inst;

  mem_stage_if #(.XLEN(32)) dmem ();

  mem_stage #(.XLEN(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ex_mem_bus_in  (ex),
    .flush          (flush),
    .stall_out      (stall_out),
    .dmem           (dmem),
    .mem_wb_bus_out (wb),
    .excpt_out      (exc),
    .excpt_inst_out (exc_inst)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic        valid;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] inst;
    logic        fl;
    logic        e_stall;
    logic [6:0]  e_op;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic [2:0]  e_exc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t        tbl [12];
  vec_t        t;
  logic [6:0]  ops [5];

  logic [31:0] rmem   [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  bit          outst, acked, e_dv, e_we, acc_we, mis;
  logic [6:0]  c_op;
  logic [4:0]  c_rd;
  logic [31:0] c_val, e_addr, e_wdata, acc_addr;
  mem_wb_bus_t e_wb;
  logic [2:0]  e_exc;
  logic [31:0] e_inst;
  logic        e_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input mem_wb_bus_t ewb, input logic [2:0] eexc,
                          input logic [31:0] einst, input logic edv);
    chk({tag, ".wb"},         {20'd0, wb},  {20'd0, ewb});
    chk({tag, ".excpt"},      64'(exc),      64'(eexc));
    chk({tag, ".excpt_inst"}, 64'(exc_inst), 64'(einst));
    chk({tag, ".dreq_valid"}, 64'(dmem.dreq_valid), 64'(edv));
  endtask

  function automatic mem_wb_bus_t mk(input logic [6:0] op, input logic [4:0] r, input logic [31:0] v);
    mk = '{opcode: op, rd: r, wb_value: v};
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    ex               = '0;
    flush            = 1'b0;
    dmem.dreq_ready  = 1'b0;
    dmem.dresp_valid = 1'b0;
    dmem.dresp_rdata = '0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] ins);
    ex = '{valid: 1'b1, opcode: op, rd: r, alu_result: a, store_data: sd, inst: ins};
  endtask

  initial begin
    ops[0] = LW; ops[1] = SW; ops[2] = ALUopR; ops[3] = ALUopI; ops[4] = 7'h37;
    //        valid op      rd     alu           sdata  inst           fl  stall e_op    e_rd   e_val         e_exc e_inst
    tbl[0]  = '{1'b1, ALUopR, 5'd5, 32'h0000_1234, '0, 32'h0000_1111, 1'b0, 1'b0, ALUopR, 5'd5, 32'h0000_1234, 3'd0, '0};
    tbl[1]  = '{1'b1, ALUopI, 5'd7, 32'hFFFF_FFFF, '0, 32'h0000_2222, 1'b0, 1'b0, ALUopI, 5'd7, 32'hFFFF_FFFF, 3'd0, '0};
    tbl[2]  = '{1'b1, 7'h37,  5'd1, 32'h1234_5000, '0, 32'h0000_3333, 1'b0, 1'b0, 7'h37,  5'd1, 32'h1234_5000, 3'd0, '0};
    tbl[3]  = '{1'b0, ALUopR, 5'd9, 32'h0000_0055, '0, 32'h0000_4444, 1'b0, 1'b0, NOP,    5'd0, 32'h0,         3'd0, '0};
    tbl[4]  = '{1'b1, ALUopR, 5'd9, 32'h0000_0066, '0, 32'h0000_5555, 1'b1, 1'b0, NOP,    5'd0, 32'h0,         3'd0, '0};
    tbl[5]  = '{1'b1, LW,     5'd3, 32'h0000_0102, '0, 32'h1020_2183, 1'b0, 1'b0, NOP,    5'd0, 32'h0,         3'd1, 32'h1020_2183};
    tbl[6]  = '{1'b1, SW,     5'd0, 32'h0000_0205, 32'h55, 32'hCAFE_0023, 1'b0, 1'b0, NOP, 5'd0, 32'h0,       3'd2, 32'hCAFE_0023};
    tbl[7]  = '{1'b1, LW,     5'd4, 32'h0000_0103, '0, 32'h0030_2203, 1'b0, 1'b0, NOP,    5'd0, 32'h0,         3'd1, 32'h0030_2203};
    tbl[8]  = '{1'b1, ALUopR, 5'd0, 32'h0000_0077, '0, 32'h0000_6666, 1'b0, 1'b0, ALUopR, 5'd0, 32'h0000_0077, 3'd0, '0};
    tbl[9]  = '{1'b1, LW,     5'd2, 32'h0000_0101, '0, 32'h0000_7777, 1'b1, 1'b0, NOP,    5'd0, 32'h0,         3'd0, '0};
    tbl[10] = '{1'b1, LW,     5'd2, 32'h0000_0100, '0, 32'h0000_8888, 1'b1, 1'b0, NOP,    5'd0, 32'h0,         3'd0, '0};
    tbl[11] = '{1'b0, SW,     5'd2, 32'h0000_0106, '0, 32'h0000_9999, 1'b0, 1'b0, NOP,    5'd0, 32'h0,         3'd0, '0};

    // Reset values while reset is held low
    reset = 1'b0;
    quiet();
    #2;
    chk_regs("reset", WB_BUBBLE, EXC_NONE, '0, 1'b0);
    chk("reset.dreq_addr",  64'(dmem.dreq_addr),  64'd0);
    chk("reset.dreq_we",    64'(dmem.dreq_we),    64'd0);
    chk("reset.dreq_wdata", 64'(dmem.dreq_wdata), 64'd0);
    chk("reset.stall",      64'(stall_out),       64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // Single-cycle behaviours from IDLE
    for (int i = 0; i < 12; i++) begin
      t  = tbl[i];
      ex = '{valid: t.valid, opcode: t.op, rd: t.rd, alu_result: t.alu, store_data: t.sdata, inst: t.inst};
      flush = t.fl;
      #1 chk($sformatf("tbl%0d.stall", i), 64'(stall_out), 64'(t.e_stall));
      tick();
      chk_regs($sformatf("tbl%0d", i), mk(t.e_op, t.e_rd, t.e_val), t.e_exc, t.e_inst, 1'b0);
    end
    quiet();
    tick();
    chk_regs("tbl.after", WB_BUBBLE, EXC_NONE, '0, 1'b0);

    // LW, ready after one REQ cycle, response on the second WAIT cycle
    drive(LW, 5'd3, 32'h100, 32'h0, 32'h1000_0183);
    #1 chk("lw.stall_issue", 64'(stall_out), 64'd1);
    tick();
    chk_regs("lw.req", WB_BUBBLE, EXC_NONE, '0, 1'b1);
    chk("lw.req.addr", 64'(dmem.dreq_addr), 64'h100);
    chk("lw.req.we",   64'(dmem.dreq_we),   64'd0);
    chk("lw.req.stall", 64'(stall_out),     64'd1);
    dmem.dreq_ready = 1'b1;
    tick();
    dmem.dreq_ready = 1'b0;
    chk_regs("lw.wait", WB_BUBBLE, EXC_NONE, '0, 1'b0);
    chk("lw.wait.addr",  64'(dmem.dreq_addr), 64'h100);
    chk("lw.wait.stall", 64'(stall_out),      64'd1);
    tick();
    dmem.dresp_valid = 1'b1;
    dmem.dresp_rdata = 32'hDEAD_BEEF;
    #1 chk("lw.resp.stall", 64'(stall_out), 64'd0);
    tick();
    quiet();
    chk_regs("lw.wb", mk(LW, 5'd3, 32'hDEAD_BEEF), EXC_NONE, '0, 1'b0);
    tick();
    chk_regs("lw.after", WB_BUBBLE, EXC_NONE, '0, 1'b0);

    // SW with ready held low for four REQ cycles
    drive(SW, 5'd6, 32'h204, 32'h55, 32'h0550_2223);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sw.hold%0d.valid", k), 64'(dmem.dreq_valid), 64'd1);
      chk($sformatf("sw.hold%0d.addr", k),  64'(dmem.dreq_addr),  64'h204);
      chk($sformatf("sw.hold%0d.wdata", k), 64'(dmem.dreq_wdata), 64'h55);
      chk($sformatf("sw.hold%0d.we", k),    64'(dmem.dreq_we),    64'd1);
      chk($sformatf("sw.hold%0d.stall", k), 64'(stall_out),       64'd1);
      tick();
    end
    dmem.dreq_ready = 1'b1;
    tick();
    dmem.dreq_ready  = 1'b0;
    dmem.dresp_valid = 1'b1;
    dmem.dresp_rdata = 32'h1357_9BDF;
    tick();
    quiet();
    chk_regs("sw.wb", mk(SW, 5'd6, 32'h0), EXC_NONE, '0, 1'b0);

    // Flush in WAIT drops the load; following ALUopI completes
    drive(LW, 5'd4, 32'h300, 32'h0, 32'h3000_0203);
    tick();
    dmem.dreq_ready = 1'b1;
    tick();
    dmem.dreq_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(ALUopI, 5'd8, 32'h42, 32'h0, 32'h0420_0413);
    #1 chk("fw.stall_wait", 64'(stall_out), 64'd1);
    dmem.dresp_valid = 1'b1;
    dmem.dresp_rdata = 32'h0000_AAAA;
    #1 chk("fw.stall_resp", 64'(stall_out), 64'd0);
    tick();
    dmem.dresp_valid = 1'b0;
    chk_regs("fw.drop", WB_BUBBLE, EXC_NONE, '0, 1'b0);
    tick();
    quiet();
    chk_regs("fw.alui", mk(ALUopI, 5'd8, 32'h42), EXC_NONE, '0, 1'b0);

    // Flush in REQ without ready aborts the request
    drive(LW, 5'd5, 32'h400, 32'h0, 32'h4000_0283);
    tick();
    flush = 1'b1;
    ex    = '0;
    tick();
    flush = 1'b0;
    chk("fr0.valid", 64'(dmem.dreq_valid), 64'd0);
    chk("fr0.stall", 64'(stall_out),       64'd0);
    tick();
    chk_regs("fr0.out", WB_BUBBLE, EXC_NONE, '0, 1'b0);

    // Flush in REQ with ready completes the handshake, response is dropped
    drive(LW, 5'd5, 32'h404, 32'h0, 32'h4040_0283);
    tick();
    flush = 1'b1;
    dmem.dreq_ready = 1'b1;
    tick();
    flush = 1'b0;
    dmem.dreq_ready = 1'b0;
    ex = '0;
    chk("fr1.valid", 64'(dmem.dreq_valid), 64'd0);
    #1 chk("fr1.stall", 64'(stall_out), 64'd1);
    dmem.dresp_valid = 1'b1;
    dmem.dresp_rdata = 32'h0000_1111;
    tick();
    quiet();
    chk_regs("fr1.out", WB_BUBBLE, EXC_NONE, '0, 1'b0);

    // Asynchronous reset between edges while in WAIT
    drive(LW, 5'd2, 32'h500, 32'h0, 32'h5000_0103);
    tick();
    dmem.dreq_ready = 1'b1;
    tick();
    dmem.dreq_ready = 1'b0;
    ex = '0;
    #2 reset = 1'b0;
    #1;
    chk_regs("areset", WB_BUBBLE, EXC_NONE, '0, 1'b0);
    chk("areset.addr",  64'(dmem.dreq_addr), 64'd0);
    chk("areset.stall", 64'(stall_out),      64'd0);
    #2 reset = 1'b1;
    tick();
    dmem.dresp_valid = 1'b1;
    dmem.dresp_rdata = 32'h0000_0BAD;
    tick();
    quiet();
    chk_regs("areset.late", WB_BUBBLE, EXC_NONE, '0, 1'b0);

    // Randomized run against the memory model
    outst = 0; acked = 0; e_dv = 0;
    e_wb = WB_BUBBLE; e_exc = EXC_NONE; e_inst = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk_regs("rnd", e_wb, e_exc, e_inst, e_dv);
      if (e_dv) begin
        chk("rnd.addr",  64'(dmem.dreq_addr),  64'(e_addr));
        chk("rnd.we",    64'(dmem.dreq_we),    64'(e_we));
        chk("rnd.wdata", 64'(dmem.dreq_wdata), 64'(e_wdata));
      end

      if (!outst) begin
        ex.valid      = ($urandom_range(0, 9) != 0);
        ex.opcode     = ops[$urandom_range(0, 4)];
        ex.rd         = 5'($urandom_range(0, 31));
        ex.store_data = $urandom;
        ex.inst       = $urandom;
        if (is_mem_op(ex.opcode)) begin
          mis = ($urandom_range(0, 4) == 0);
          ex.alu_result = 32'h1000 + 32'($urandom_range(0, 15)) * 4 + (mis ? 32'($urandom_range(1, 3)) : 32'd0);
        end else begin
          ex.alu_result = $urandom;
        end
        flush = ($urandom_range(0, 9) == 0);
      end else begin
        flush = 1'b0;
      end
      dmem.dreq_ready = outst && !acked && ($urandom_range(0, 1) == 1);
      if (outst && acked) begin
        dmem.dresp_valid = ($urandom_range(0, 1) == 1);
        dmem.dresp_rdata = acc_we ? $urandom
                         : (rmem.exists(acc_addr) ? rmem[acc_addr] : init_word(acc_addr));
      end else begin
        dmem.dresp_valid = ($urandom_range(0, 7) == 0);
        dmem.dresp_rdata = $urandom;
      end

      #1;
      e_stall = outst ? !(acked && dmem.dresp_valid)
                      : (ex.valid && !flush && is_mem_op(ex.opcode) && (ex.alu_result[1:0] == 2'b00));
      chk("rnd.stall", 64'(stall_out), 64'(e_stall));

      if (dmem.dreq_ready && dmem.dreq_valid) begin
        acc_addr = dmem.dreq_addr;
        acc_we   = dmem.dreq_we;
        if (acc_we) rmem[acc_addr] = dmem.dreq_wdata;
      end

      e_wb = WB_BUBBLE; e_exc = EXC_NONE; e_inst = '0;
      if (!outst) begin
        if (ex.valid && !flush) begin
          if (!is_mem_op(ex.opcode)) begin
            e_wb = mk(ex.opcode, ex.rd, ex.alu_result);
          end else if (ex.alu_result[1:0] != 2'b00) begin
            e_exc  = (ex.opcode == LW) ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
            e_inst = ex.inst;
          end else begin
            outst = 1; acked = 0; e_dv = 1;
            c_op = ex.opcode; c_rd = ex.rd;
            e_addr = ex.alu_result; e_we = (ex.opcode == SW); e_wdata = ex.store_data;
            if (e_we) shadow[e_addr] = ex.store_data;
            else c_val = shadow.exists(e_addr) ? shadow[e_addr] : init_word(e_addr);
          end
        end
      end else if (!acked) begin
        if (dmem.dreq_ready) begin
          acked = 1; e_dv = 0;
        end
      end else if (dmem.dresp_valid) begin
        outst = 0;
        e_wb  = (c_op == LW) ? mk(LW, c_rd, c_val) : mk(SW, c_rd, 32'h0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and writeback.
- Consumes the EX/MEM bus and performs LW/SW through a valid/ready data-memory port.
- Stalls upstream while an access is outstanding.
- Produces mem_wb_bus_t, the record the register file consumes to write rd. Misaligned accesses are reported on the exception lines that feed the register file's exception capture.

Parameters:
XLEN, 32, data and address width.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (reset==0 resets immediately, independent of clock).
ex_mem_bus_in  in  ex_mem_bus_t  fields: valid, opcode[6:0], rd[4:0], alu_result[XLEN-1:0], store_data[XLEN-1:0], inst[31:0].
flush  in  1  kill the instruction held or arriving in this stage.
stall_out  out  1  upstream must hold ex_mem_bus_in stable.
dreq_valid  out  1  data-memory request valid.
dreq_ready  in  1  memory accepts the request.
dreq_we  out  1  1=store, 0=load.
dreq_addr  out  XLEN  word address (byte-addressed, [1:0]==0).
dreq_wdata  out  XLEN  store data.
dresp_valid  in  1  read data or store acknowledge.
dresp_rdata  in  XLEN  load data.
mem_wb_bus_out  out  mem_wb_bus_t  fields: opcode, rd, wb_value.
excpt_out  out  3  exception code, 0 = none.
excpt_inst_out  out  32  faulting instruction word.

Behaviour:
- Reset values, all registered outputs:
  - state=IDLE, drop=0.
  - mem_wb_bus_out = {NOP, 0, 0}.
  - dreq_valid=0, dreq_we=0, dreq_addr=0, dreq_wdata=0.
  - excpt_out=0, excpt_inst_out=0.
- Reset mid-access abandons the transaction. Any late dresp_valid is ignored because state is IDLE.
- Bubble: mem_wb_bus_out.opcode=NOP, rd=0, wb_value=0. The register file ignores it.
- FSM states: IDLE, REQ, WAIT.
- IDLE, ex valid=0 or flush=1: next mem_wb_bus_out is a bubble.
- IDLE, non-memory op (ALUopR, ALUopI, others): mem_wb_bus_out <= {opcode, rd, alu_result}. Latency is 1 cycle. stall_out=0.
- IDLE, LW/SW with alu_result[1:0]!=0:
  - No request is issued.
  - For exactly one cycle: excpt_out <= EXC_LOAD_MISALIGN (LW) or EXC_STORE_MISALIGN (SW), excpt_inst_out <= inst. mem_wb_bus_out is a bubble.
  - stall_out=0.
  - excpt_out returns to 0 the next cycle unless a new fault occurs.
- IDLE, LW/SW aligned:
  - stall_out=1 (combinational from input) that cycle.
  - Latch opcode, rd, addr, wdata. Drive dreq_valid=1 and go to REQ. mem_wb_bus_out is a bubble.
- REQ:
  - dreq_valid=1. dreq_addr, dreq_we and dreq_wdata stay stable until dreq_ready. stall_out=1. Output is a bubble.
  - On dreq_ready: dreq_valid <= 0 and go to WAIT.
- WAIT:
  - stall_out=1 except in the cycle dresp_valid=1, where stall_out=0 so upstream advances in the same cycle.
  - On dresp_valid:
    - LW: mem_wb_bus_out <= {LW, rd, dresp_rdata}.
    - SW: mem_wb_bus_out <= {SW, rd, 0}. The register file does not write on SW.
    - Go to IDLE.
  - The instruction presented while stall_out=0 in the response cycle is not processed. The next instruction is taken in IDLE.
- Minimum LW latency: 3 cycles (IDLE→REQ→WAIT, response in the first WAIT cycle).
- Flush handling:
  - Flush in REQ with dreq_ready=0: abort to IDLE and drop dreq_valid.
  - Flush in REQ with dreq_ready=1: the handshake completes. Go to WAIT with drop=1.
  - Flush in WAIT: drop=1.
  - When drop=1, the response is consumed, a bubble is output, and drop is cleared.
- LW with rd==0 still performs the memory access.
- dresp_valid in IDLE or REQ is ignored.

Decomposition:
- Shared pipeline package holds: ex_mem_bus_t; mem_wb_bus_t; opcode constants LW, SW, ALUopR, ALUopI, NOP; exception codes EXC_NONE=0, EXC_LOAD_MISALIGN=1, EXC_STORE_MISALIGN=2; mem_state_t enum.
- One sub-module: mem_req_fsm (IDLE/REQ/WAIT, drop flag, dreq_* registers, stall_out generation). The top level handles the output bus and exception muxing.

Test Plan:
- ALUopR, rd=5, alu_result=0x1234 → next cycle mem_wb_bus_out={ALUopR,5,0x1234}; stall_out stays 0.
- LW, rd=3, addr=0x100; dreq_ready one cycle later; dresp_rdata=0xDEADBEEF 2 cycles later → dreq_addr=0x100 stable while waiting; mem_wb_bus_out={LW,3,0xDEADBEEF}; stall_out falls in the response cycle.
- SW, addr=0x204, data=0x55, dreq_ready held low for 4 cycles → dreq_valid, addr and wdata stable for those 4 cycles; after the ack, output opcode=SW.
- LW, addr=0x102 → excpt_out=1 and excpt_inst_out=inst for exactly 1 cycle; no dreq_valid; bubble output.
- LW accepted, then flush in WAIT; response 0xAAAA arrives → bubble output (no LW writeback); next ALUopI completes normally.
- LW in WAIT; reset driven low asynchronously between clock edges → all outputs return to reset values immediately; a later dresp_valid produces no writeback.
